transpose_tile_drain: RTL

- Sink for the transpose switch network.
- Captures each complete NUM_PE x NUM_PE tile in one cycle when the network's output-valid asserts.
- Streams the tile to the memory-group write side one row per cycle over a valid/ready handshake.
- Two-slot ping-pong buffer hides row back-pressure. tile_ready lets the transpose controller gate its in_val issue.

---
 rtl/transpose_pkg.sv | 30 +++
 rtl/transpose_tile_slot.sv | 25 ++
 rtl/transpose_tile_drain.sv | 114 +++++++++++
 3 files changed

// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared tile types and width helpers for the transpose datapath
package transpose_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_MG     = 8;
    localparam int DEF_NUM_PE     = DEF_NUM_MG;

    function automatic int calc_chunk_width(input int num_mg, input int num_pe, input int data_width);
        return (num_mg / num_pe) * data_width;
    endfunction

    function automatic int calc_idx_w(input int num_pe);
        return (num_pe > 1) ? $clog2(num_pe) : 1;
    endfunction

    localparam int DEF_CHUNK_WIDTH = calc_chunk_width(DEF_NUM_MG, DEF_NUM_PE, DEF_DATA_WIDTH);
    localparam int DEF_IDX_W       = calc_idx_w(DEF_NUM_PE);

    typedef logic [DEF_CHUNK_WIDTH-1:0] chunk_t;
    typedef chunk_t [DEF_NUM_PE-1:0]    row_t;
    typedef row_t [DEF_NUM_PE-1:0]      tile_t;

    // Encoding equals the number of buffered tiles, so occupancy is the state itself.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/transpose_tile_slot.sv
// rtl/transpose_tile_slot.sv - one tile register, whole-tile write, row-select read
module transpose_tile_slot #(
    parameter int NUM_PE      = 8,
    parameter int CHUNK_WIDTH = 64,
    parameter int IDX_W       = 3
) (
    input  logic                                      clk,
    input  logic                                      we,
    input  logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] tile,
    input  logic [IDX_W-1:0]                          sel,
    output logic [NUM_PE-1:0][CHUNK_WIDTH-1:0]        row
);

    logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] mem;

    // Contents are deliberately not reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            mem <= tile;
        end
    end

    assign row = mem[sel];

endmodule

// File: rtl/transpose_tile_drain.sv
// rtl/transpose_tile_drain.sv - ping-pong tile sink streaming one row per cycle
module transpose_tile_drain
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_MG     = 8,
    parameter int NUM_PE     = NUM_MG,
    localparam int CHUNK_WIDTH = calc_chunk_width(NUM_MG, NUM_PE, DATA_WIDTH),
    localparam int IDX_W       = calc_idx_w(NUM_PE)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] tile_in,
    input  logic                                           tile_val,
    output logic                                           tile_ready,
    output logic [NUM_PE-1:0][CHUNK_WIDTH-1:0]             row_out,
    output logic [IDX_W-1:0]                               row_idx,
    output logic                                           row_val,
    input  logic                                           row_rdy,
    output logic                                           row_last,
    output logic [1:0]                                     occupancy,
    output logic                                           overflow
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PE - 1);

    occ_state_t       state, state_nxt;
    logic             wr_ptr, wr_ptr_nxt;
    logic             rd_ptr, rd_ptr_nxt;
    logic [IDX_W-1:0] row_cnt, row_cnt_nxt;
    logic             overflow_q, overflow_nxt;

    logic capture;
    logic xfer;
    logic retire;
    logic [NUM_PE-1:0][CHUNK_WIDTH-1:0] slot_row [2];

    assign tile_ready = (state != OCC_FULL);
    assign row_val    = (state != OCC_EMPTY);
    assign capture    = tile_val && tile_ready;
    assign xfer       = row_val && row_rdy;
    assign retire     = xfer && (row_cnt == LAST_ROW);

    assign row_out   = slot_row[rd_ptr];
    assign row_idx   = row_cnt;
    assign row_last  = row_val && (row_cnt == LAST_ROW);
    assign occupancy = state;
    assign overflow  = overflow_q;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        transpose_tile_slot #(
            .NUM_PE      (NUM_PE),
            .CHUNK_WIDTH (CHUNK_WIDTH),
            .IDX_W       (IDX_W)
        ) u_slot (
            .clk  (clk),
            .we   (capture && (wr_ptr == 1'(s))),
            .tile (tile_in),
            .sel  (row_cnt),
            .row  (slot_row[s])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OCC_EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            row_cnt    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            row_cnt    <= row_cnt_nxt;
            overflow_q <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        row_cnt_nxt  = row_cnt;
        overflow_nxt = overflow_q;

        if (tile_val && !tile_ready) begin
            overflow_nxt = 1'b1;
        end
        if (capture) begin
            wr_ptr_nxt = ~wr_ptr;
        end
        if (xfer) begin
            if (retire) begin
                row_cnt_nxt = '0;
                rd_ptr_nxt  = ~rd_ptr;
            end else begin
                row_cnt_nxt = row_cnt + IDX_W'(1);
            end
        end

        // Capture and retire in the same cycle cancel out.
        case (state)
            OCC_EMPTY: if (capture) state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (capture && !retire)      state_nxt = OCC_FULL;
                else if (retire && !capture) state_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (retire) state_nxt = OCC_ONE;
            default:   state_nxt = OCC_EMPTY;
        endcase
    end

endmodule
